// File: rtl/output_arbiter.sv
// rtl/output_arbiter.sv - round-robin output arbiter with tenure timeout and transaction counting
module output_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [NUM_MASTERS-1:0] i_Req,
  input  logic [NUM_MASTERS-1:0] i_NewTransaction,
  input  logic                   i_ClearTimeout,
  output logic [NUM_MASTERS-1:0] o_Grant,
  output logic [1:0]             o_Owner,
  output logic                   o_Busy,
  output logic [7:0]             o_TransCount,
  output logic                   o_Timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TIMEOUT_PRE = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT_0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_next;
  logic [NUM_MASTERS-1:0] grant_next;
  logic [1:0]             owner_next;
  logic [7:0]             count_next;
  logic [15:0]            tenure;
  logic [15:0]            tenure_next;
  logic                   timeout_next;

  logic                   rr_found;
  logic [1:0]             rr_winner;
  logic [1:0]             rr_idx;

  // Search starts one past the current owner, so the last owner is always lowest priority.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = o_Owner;
    rr_idx    = o_Owner;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = o_Owner + 2'(i);
      if (!rr_found && i_Req[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = o_Grant;
    owner_next   = o_Owner;
    count_next   = o_TransCount;
    tenure_next  = tenure;
    timeout_next = o_Timeout;

    if (i_ClearTimeout) begin
      timeout_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (rr_found) begin
          state_next  = BUSY;
          grant_next  = ONE_HOT_0 << rr_winner;
          owner_next  = rr_winner;
          count_next  = 8'd1;
          tenure_next = 16'd1;
        end
      end
      BUSY: begin
        if (i_Req[o_Owner]) begin
          if (i_NewTransaction[o_Owner] && (o_TransCount != 8'hFF)) begin
            count_next = o_TransCount + 8'd1;
          end
          if (tenure != TIMEOUT_VAL) begin
            tenure_next = tenure + 16'd1;
          end
          // Fires only on the edge the limit is reached, so a clear after saturation sticks.
          if (tenure == TIMEOUT_PRE) begin
            timeout_next = 1'b1;
          end
        end else if (rr_found) begin
          grant_next  = ONE_HOT_0 << rr_winner;
          owner_next  = rr_winner;
          count_next  = 8'd1;
          tenure_next = 16'd1;
        end else begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= IDLE;
      o_Grant      <= '0;
      o_Owner      <= 2'd3;
      o_Busy       <= 1'b0;
      o_TransCount <= 8'd0;
      o_Timeout    <= 1'b0;
      tenure       <= 16'd0;
    end else begin
      state        <= state_next;
      o_Grant      <= grant_next;
      o_Owner      <= owner_next;
      o_Busy       <= (state_next == BUSY);
      o_TransCount <= count_next;
      o_Timeout    <= timeout_next;
      tenure       <= tenure_next;
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// tb/tb_output_arbiter.sv - directed self-checking bench for output_arbiter
module tb_output_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] new_txn;
  logic       clear_to;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [7:0] trans_count;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int exp_owner;

  always #5 clk = ~clk;

  output_arbiter #(
    .NUM_MASTERS    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_Req            (req),
    .i_NewTransaction (new_txn),
    .i_ClearTimeout   (clear_to),
    .o_Grant          (grant),
    .o_Owner          (owner),
    .o_Busy           (busy),
    .o_TransCount     (trans_count),
    .o_Timeout        (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic b, input logic [7:0] tc);
    chk({tag, " grant"}, 32'(grant), 32'(g));
    chk({tag, " owner"}, 32'(owner), 32'(o));
    chk({tag, " busy"}, 32'(busy), 32'(b));
    chk({tag, " count"}, 32'(trans_count), 32'(tc));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    new_txn  = 4'b0000;
    clear_to = 1'b0;
    step();
    step();
    chk_state("reset", 4'b0000, 2'd3, 1'b0, 8'd0);
    chk("reset timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step();
    chk_state("post_release", 4'b0000, 2'd3, 1'b0, 8'd0);

    // First grant after reset: priority starts at master 0
    req = 4'b1010;
    step();
    chk_state("first_grant", 4'b0010, 2'd1, 1'b1, 8'd1);

    // Owner 1 holds with three own pulses plus an ignored non-owner pulse
    for (int i = 0; i < 9; i++) begin
      new_txn = (i == 1 || i == 4 || i == 6) ? 4'b0010 : ((i == 2) ? 4'b1000 : 4'b0000);
      step();
      chk("hold grant", 32'(grant), 32'(4'b0010));
    end
    new_txn = 4'b0000;
    chk("hold count", 32'(trans_count), 32'd4);
    req = 4'b1000;
    step();
    chk_state("handover_3", 4'b1000, 2'd3, 1'b1, 8'd1);

    // Owner drops with no other request: idle, owner and count retained
    req = 4'b0000;
    step();
    chk_state("to_idle", 4'b0000, 2'd3, 1'b0, 8'd1);
    new_txn = 4'b1000;
    step();
    new_txn = 4'b0000;
    chk_state("idle_hold", 4'b0000, 2'd3, 1'b0, 8'd1);

    // All four request; each drops for one cycle after five granted cycles
    req = 4'b1111;
    step();
    exp_owner = 0;
    chk_state("rr_start", 4'b0001, 2'd0, 1'b1, 8'd1);
    for (int t = 0; t < 5; t++) begin
      for (int c = 1; c < 5; c++) begin
        step();
        chk("rr_hold grant", 32'(grant), 32'(4'b0001 << exp_owner));
      end
      req = 4'b1111 & ~(4'b0001 << exp_owner);
      step();
      exp_owner = (exp_owner + 1) % 4;
      chk("rr_next grant", 32'(grant), 32'(4'b0001 << exp_owner));
      chk("rr_next busy", 32'(busy), 32'd1);
      req = 4'b1111;
    end

    req = 4'b0000;
    step();
    chk_state("rr_idle", 4'b0000, 2'd1, 1'b0, 8'd1);

    // Tenure timeout with own transactions every cycle
    req     = 4'b0001;
    new_txn = 4'b0001;
    step();
    chk_state("to_grant", 4'b0001, 2'd0, 1'b1, 8'd1);
    for (int i = 1; i < 15; i++) begin
      step();
      chk("to_before", 32'(timeout), 32'd0);
    end
    step();
    chk("to_reached", 32'(timeout), 32'd1);
    chk("to_grant_kept", 32'(grant), 32'(4'b0001));
    chk("to_count", 32'(trans_count), 32'd16);
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("to_sticky", 32'(timeout), 32'd1);
    clear_to = 1'b1;
    step();
    clear_to = 1'b0;
    chk("to_cleared", 32'(timeout), 32'd0);
    for (int i = 0; i < 250; i++) begin
      step();
    end
    chk_state("count_sat", 4'b0001, 2'd0, 1'b1, 8'd255);
    chk("to_stays_clear", 32'(timeout), 32'd0);
    new_txn = 4'b0000;
    req     = 4'b0000;
    step();
    chk_state("sat_idle", 4'b0000, 2'd0, 1'b0, 8'd255);

    // Clear coinciding with a fresh timeout: set wins
    req = 4'b0100;
    step();
    chk_state("grant_2", 4'b0100, 2'd2, 1'b1, 8'd1);
    for (int i = 1; i < 15; i++) begin
      step();
    end
    chk("pre_coincide", 32'(timeout), 32'd0);
    clear_to = 1'b1;
    step();
    clear_to = 1'b0;
    chk("set_wins", 32'(timeout), 32'd1);

    // Asynchronous reset mid-burst
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_reset", 4'b0000, 2'd3, 1'b0, 8'd0);
    chk("async_reset timeout", 32'(timeout), 32'd0);
    req = 4'b0110;
    #2;
    rst_n = 1'b1;
    step();
    chk_state("after_reset", 4'b0010, 2'd1, 1'b1, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001: Parameter NUM_MASTERS, default 4, number of requesting decoders; fixed at 4 for this revision.
REQ-002: Parameter TIMEOUT_CYCLES, default 1024, ownership-duration limit in cycles; legal range 2..65535.
REQ-003: i_Clk  input  1  single clock; all state updates on rising edge.
REQ-004: i_Rst_n  input  1  asynchronous, active-low reset.
REQ-005: i_Req  input  4  per-master request from each decoder's slave-port slot; held high for a whole transaction/burst.
REQ-006: i_NewTransaction  input  4  per-master single-cycle pulse marking the start of a transaction.
REQ-007: i_ClearTimeout  input  1  synchronous clear of the sticky timeout flag.
REQ-008: o_Grant  output  4  registered one-hot grant to the slave mux; all-zero when idle.
REQ-009: o_Owner  output  2  index of the granted master; holds last owner when idle.
REQ-010: o_Busy  output  1  high while a grant is held.
REQ-011: o_TransCount  output  8  owner's transaction count in the current tenure, saturating.
REQ-012: o_Timeout  output  1  sticky flag: one tenure reached TIMEOUT_CYCLES.

Function
REQ-013: The block SHALL implement two states: IDLE (o_Grant=0, o_Busy=0) and BUSY (exactly one o_Grant bit set, o_Busy=1).
REQ-014: All outputs SHALL be registered; grant latency from first i_Req assertion in IDLE SHALL be exactly 1 cycle.
REQ-015: IDLE -> BUSY when any i_Req bit is high; winner chosen round-robin.
REQ-016: Round-robin priority SHALL start at (o_Owner+1) mod 4 and ascend with wrap; the last owner has lowest priority.
REQ-017: In BUSY, grant SHALL be held unchanged while i_Req[o_Owner]=1, regardless of other requests or i_NewTransaction pulses.
REQ-018: In BUSY with i_Req[o_Owner]=0 and other requests pending, the next owner SHALL be granted on the following edge (BUSY -> BUSY, no idle cycle).
REQ-019: In BUSY with i_Req[o_Owner]=0 and no requests, state SHALL return to IDLE on the following edge.
REQ-020: A master whose request drops and re-rises the next cycle while another master waits SHALL lose arbitration to the waiting master.
REQ-021: On each new grant o_TransCount SHALL load 1; in BUSY, each cycle with i_Req[o_Owner]=1 and i_NewTransaction[o_Owner]=1 SHALL increment it, saturating at 255.
REQ-022: i_NewTransaction bits of non-owners SHALL be ignored; o_TransCount SHALL hold its value in IDLE.
REQ-023: A 16-bit tenure counter SHALL load 1 on each new grant and increment each BUSY cycle, saturating at TIMEOUT_CYCLES.
REQ-024: When the tenure counter reaches TIMEOUT_CYCLES, o_Timeout SHALL set on that edge and stay set until i_ClearTimeout or reset; arbitration is unaffected (no preemption).
REQ-025: If i_ClearTimeout and a new timeout coincide, set SHALL win.

Reset
REQ-026: Asserting i_Rst_n=0 SHALL immediately force: state IDLE, o_Grant=0, o_Busy=0, o_Owner=3, o_TransCount=0, o_Timeout=0, tenure counter 0.
REQ-027: Reset mid-tenure SHALL drop the grant without waiting for i_Req; after release, master 0 has highest priority.
REQ-028: First rising edge after deassertion SHALL evaluate i_Req normally.

Verification
REQ-029: After reset, i_Req=4'b1010 -> next edge o_Grant=4'b0010, o_Owner=1, o_TransCount=1.
REQ-030: Owner 1 holds i_Req for 10 cycles with 3 i_NewTransaction[1] pulses and i_Req[3] high -> grant steady, o_TransCount=4; i_Req[1] drops -> next edge o_Grant=4'b1000.
REQ-031: All four masters request continuously, each dropping its request for 1 cycle after 5 granted cycles -> grant order 0,1,2,3,0 with no IDLE cycle between tenures.
REQ-032: Single owner holds i_Req for TIMEOUT_CYCLES+5 cycles -> o_Timeout rises when tenure counter reaches TIMEOUT_CYCLES, grant unchanged; i_ClearTimeout pulse -> o_Timeout=0 next edge.
REQ-033: i_Rst_n pulsed low mid-burst with o_Grant=4'b0100 -> o_Grant=0 immediately; after release with i_Req=4'b0110 -> o_Grant=4'b0010.
REQ-034: Owner's i_Req drops with no other requests -> o_Busy=0, o_Grant=0 next edge, o_Owner and o_TransCount retained.
